// File: rtl/biriscv_mul_dispatch_pkg.sv
// Shared types and constants for the multiply dispatch block.
// Optional skid entry is enabled with BIRISCV_MUL_DISPATCH_SKID_EN.
package biriscv_mul_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } mul_state_e;

    localparam int unsigned MUL_TIMEOUT_CYCLES = 16;
    localparam int unsigned MUL_TIMEOUT_W      = 5;
    localparam int unsigned MUL_RESP_LATENCY   = 5;

    typedef struct packed {
        logic [31:0] opcode;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] ra;
        logic [31:0] rb;
    } mul_op_t;

    function automatic logic op_has_rd(input mul_op_t op);
        return op.rd != '0;
    endfunction

endpackage

// File: rtl/biriscv_mul_dispatch_slot.sv
// Payload register for one multiply op with load/clear and an occupancy bit.
module biriscv_mul_dispatch_slot
    import biriscv_mul_dispatch_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    load_i,
    input  logic    clear_i,
    input  mul_op_t op_i,
    output logic    valid_o,
    output mul_op_t op_o
);

    logic    valid_q;
    mul_op_t op_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            op_q    <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            op_q    <= op_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;

endmodule

// File: rtl/biriscv_mul_dispatch.sv
// Dispatches one multiply op to the iterative multiplier and holds its result for writeback.
// Define BIRISCV_MUL_DISPATCH_SKID_EN to add a one-entry skid buffer on the issue side.
module biriscv_mul_dispatch
    import biriscv_mul_dispatch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MUL_TIMEOUT_CYCLES,
    parameter int unsigned TIMEOUT_W      = MUL_TIMEOUT_W
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic [31:0] issue_opcode_i,
    input  logic [31:0] issue_pc_i,
    input  logic [4:0]  issue_rd_idx_i,
    input  logic [31:0] issue_ra_operand_i,
    input  logic [31:0] issue_rb_operand_i,
    output logic        mul_valid_o,
    output logic [31:0] mul_opcode_o,
    output logic [31:0] mul_pc_o,
    output logic [4:0]  mul_rd_idx_o,
    output logic [31:0] mul_ra_operand_o,
    output logic [31:0] mul_rb_operand_o,
    input  logic        mul_writeback_valid_i,
    input  logic [31:0] mul_writeback_value_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_idx_o,
    output logic [31:0] wb_pc_o,
    output logic [31:0] wb_value_o,
    input  logic        wb_accept_i,
    output logic        pending_valid_o,
    output logic [4:0]  pending_rd_idx_o,
    output logic        error_o
);

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    mul_state_e           state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 wbv_q, wbv_d;
    logic [31:0]          wbval_q, wbval_d;
    logic [31:0]          wbpc_q, wbpc_d;
    logic [4:0]           wbrd_q, wbrd_d;

    mul_op_t issue_op;
    mul_op_t main_op;
    mul_op_t idle_src;
    logic    idle_src_valid;
    logic    main_valid;
    logic    main_load;
    logic    main_clear;
    logic    accept;

    assign issue_op = '{opcode: issue_opcode_i, pc: issue_pc_i, rd: issue_rd_idx_i,
                        ra: issue_ra_operand_i, rb: issue_rb_operand_i};
    assign accept   = issue_valid_i && issue_ready_o;

`ifdef BIRISCV_MUL_DISPATCH_SKID_EN
    mul_op_t skid_op;
    logic    skid_valid;
    logic    skid_load;
    logic    skid_pop;

    // A full skid entry takes precedence in IDLE; ready is low then, so no new op competes.
    assign issue_ready_o  = !skid_valid;
    assign skid_load      = accept && (state_q != ST_IDLE);
    assign skid_pop       = (state_q == ST_IDLE) && skid_valid;
    assign idle_src       = skid_valid ? skid_op : issue_op;
    assign idle_src_valid = skid_valid || accept;

    biriscv_mul_dispatch_slot u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (skid_load),
        .clear_i (skid_pop),
        .op_i    (issue_op),
        .valid_o (skid_valid),
        .op_o    (skid_op)
    );
`else
    assign issue_ready_o  = (state_q == ST_IDLE);
    assign idle_src       = issue_op;
    assign idle_src_valid = accept;
`endif

    biriscv_mul_dispatch_slot u_main (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (main_load),
        .clear_i (main_clear),
        .op_i    (idle_src),
        .valid_o (main_valid),
        .op_o    (main_op)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        wbv_d      = wbv_q;
        wbval_d    = wbval_q;
        wbpc_d     = wbpc_q;
        wbrd_d     = wbrd_q;
        main_load  = 1'b0;
        main_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // rd==0 ops have no architectural effect and are simply dropped.
                if (idle_src_valid && op_has_rd(idle_src)) begin
                    main_load = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (mul_writeback_valid_i) begin
                    wbv_d   = 1'b1;
                    wbval_d = mul_writeback_value_i;
                    wbpc_d  = main_op.pc;
                    wbrd_d  = main_op.rd;
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    err_d      = 1'b1;
                    main_clear = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (wb_accept_i) begin
                    wbv_d      = 1'b0;
                    main_clear = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wbv_q   <= 1'b0;
            wbval_q <= '0;
            wbpc_q  <= '0;
            wbrd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            wbv_q   <= wbv_d;
            wbval_q <= wbval_d;
            wbpc_q  <= wbpc_d;
            wbrd_q  <= wbrd_d;
        end
    end

    assign mul_valid_o      = (state_q == ST_ISSUE);
    assign mul_opcode_o     = main_op.opcode;
    assign mul_pc_o         = main_op.pc;
    assign mul_rd_idx_o     = main_op.rd;
    assign mul_ra_operand_o = main_op.ra;
    assign mul_rb_operand_o = main_op.rb;
    assign wb_valid_o       = wbv_q;
    assign wb_value_o       = wbval_q;
    assign wb_pc_o          = wbpc_q;
    assign wb_rd_idx_o      = wbrd_q;
    assign pending_valid_o  = main_valid;
    assign pending_rd_idx_o = main_op.rd;
    assign error_o          = err_q;

endmodule

// File: tb/tb_biriscv_mul_dispatch.sv
// Directed plus randomized bench for biriscv_mul_dispatch with a stub multiplier.
// Skid scenario runs only when BIRISCV_MUL_DISPATCH_SKID_EN is defined.
module tb_biriscv_mul_dispatch;
    import biriscv_mul_dispatch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_opcode_i;
    logic [31:0] issue_pc_i;
    logic [4:0]  issue_rd_idx_i;
    logic [31:0] issue_ra_operand_i;
    logic [31:0] issue_rb_operand_i;
    logic        mul_valid_o;
    logic [31:0] mul_opcode_o;
    logic [31:0] mul_pc_o;
    logic [4:0]  mul_rd_idx_o;
    logic [31:0] mul_ra_operand_o;
    logic [31:0] mul_rb_operand_o;
    logic        mul_writeback_valid_i;
    logic [31:0] mul_writeback_value_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_idx_o;
    logic [31:0] wb_pc_o;
    logic [31:0] wb_value_o;
    logic        wb_accept_i;
    logic        pending_valid_o;
    logic [4:0]  pending_rd_idx_o;
    logic        error_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stub multiplier state
    bit          stub_en    = 1'b1;
    int          due        = -1;
    logic [31:0] due_val    = '0;
    int          spur_cyc   = -1;
    int          mulv_count = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    biriscv_mul_dispatch #(.TIMEOUT_CYCLES(16), .TIMEOUT_W(5)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst_i),
        .issue_valid_i         (issue_valid_i),
        .issue_ready_o         (issue_ready_o),
        .issue_opcode_i        (issue_opcode_i),
        .issue_pc_i            (issue_pc_i),
        .issue_rd_idx_i        (issue_rd_idx_i),
        .issue_ra_operand_i    (issue_ra_operand_i),
        .issue_rb_operand_i    (issue_rb_operand_i),
        .mul_valid_o           (mul_valid_o),
        .mul_opcode_o          (mul_opcode_o),
        .mul_pc_o              (mul_pc_o),
        .mul_rd_idx_o          (mul_rd_idx_o),
        .mul_ra_operand_o      (mul_ra_operand_o),
        .mul_rb_operand_o      (mul_rb_operand_o),
        .mul_writeback_valid_i (mul_writeback_valid_i),
        .mul_writeback_value_i (mul_writeback_value_i),
        .wb_valid_o            (wb_valid_o),
        .wb_rd_idx_o           (wb_rd_idx_o),
        .wb_pc_o               (wb_pc_o),
        .wb_value_o            (wb_value_o),
        .wb_accept_i           (wb_accept_i),
        .pending_valid_o       (pending_valid_o),
        .pending_rd_idx_o      (pending_rd_idx_o),
        .error_o               (error_o)
    );

    // Stub multiplier: answers MUL_RESP_LATENCY cycles after each start pulse.
    initial begin
        mul_writeback_valid_i = 1'b0;
        mul_writeback_value_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mul_valid_o) begin
                mulv_count++;
                if (stub_en) begin
                    due     = cyc + int'(MUL_RESP_LATENCY);
                    due_val = mul_ra_operand_o * mul_rb_operand_o;
                end
            end
            if (cyc == spur_cyc) begin
                mul_writeback_valid_i = 1'b1;
                mul_writeback_value_i = 32'h55;
            end else if (cyc == due) begin
                mul_writeback_valid_i = 1'b1;
                mul_writeback_value_i = due_val;
            end else begin
                mul_writeback_valid_i = 1'b0;
                mul_writeback_value_i = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] pc);
        issue_valid_i      = 1'b1;
        issue_ra_operand_i = a;
        issue_rb_operand_i = b;
        issue_rd_idx_i     = rd;
        issue_pc_i         = pc;
        issue_opcode_i     = 32'h02000033 | {20'd0, rd, 7'd0};
    endtask

    task automatic wait_wb(input string tag);
        int n = 0;
        while (!wb_valid_o && n < 40) begin
            tick();
            n++;
        end
        check(tag, wb_valid_o, 1);
    endtask

    // Full transaction with the expected timeline derived from the latency rules.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] pc, input int hold, input logic exp_err);
        logic [31:0] prod;
        logic [31:0] opc;
        logic        busy_ready;
        prod = a * b;
        opc  = 32'h02000033 | {20'd0, rd, 7'd0};
`ifdef BIRISCV_MUL_DISPATCH_SKID_EN
        busy_ready = 1'b1;
`else
        busy_ready = 1'b0;
`endif
        check("ready_idle", issue_ready_o, 1);
        offer(a, b, rd, pc);
        tick();
        issue_valid_i = 1'b0;
        if (rd == 5'd0) begin
            repeat (9) begin
                check("rd0_mulv", mul_valid_o, 0);
                check("rd0_wbv", wb_valid_o, 0);
                check("rd0_pend", pending_valid_o, 0);
                check("rd0_ready", issue_ready_o, 1);
                tick();
            end
            return;
        end
        check("start_pulse", mul_valid_o, 1);
        check("mul_ra", mul_ra_operand_o, a);
        check("mul_rb", mul_rb_operand_o, b);
        check("mul_rd", mul_rd_idx_o, rd);
        check("mul_pc", mul_pc_o, pc);
        check("mul_opc", mul_opcode_o, opc);
        check("pend_v", pending_valid_o, 1);
        check("pend_rd", pending_rd_idx_o, rd);
        check("ready_busy", issue_ready_o, busy_ready);
        for (int k = 2; k <= 6; k++) begin
            tick();
            check("single_pulse", mul_valid_o, 0);
            check("wbv_early", wb_valid_o, 0);
        end
        tick();
        check("wbv_n7", wb_valid_o, 1);
        check("wb_value", wb_value_o, prod);
        check("wb_rd", wb_rd_idx_o, rd);
        check("wb_pc", wb_pc_o, pc);
        check("err_sticky", error_o, exp_err);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_wbv", wb_valid_o, 1);
            check("hold_value", wb_value_o, prod);
            check("hold_rd", wb_rd_idx_o, rd);
            check("hold_pc", wb_pc_o, pc);
            check("hold_ready", issue_ready_o, busy_ready);
            check("hold_pend", pending_valid_o, 1);
            check("hold_pend_rd", pending_rd_idx_o, rd);
        end
        wb_accept_i = 1'b1;
        tick();
        wb_accept_i = 1'b0;
        check("acc_wbv", wb_valid_o, 0);
        check("acc_pend", pending_valid_o, 0);
        check("acc_ready", issue_ready_o, 1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] pc;
        logic [4:0]  rd;
        int          mv0;

        rst_i              = 1'b1;
        issue_valid_i      = 1'b0;
        issue_opcode_i     = '0;
        issue_pc_i         = '0;
        issue_rd_idx_i     = '0;
        issue_ra_operand_i = '0;
        issue_rb_operand_i = '0;
        wb_accept_i        = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_ready", issue_ready_o, 1);
        check("rst_mulv", mul_valid_o, 0);
        check("rst_wbv", wb_valid_o, 0);
        check("rst_pend", pending_valid_o, 0);
        check("rst_err", error_o, 0);
        check("rst_mulrd", mul_rd_idx_o, 0);

        // basic and backpressure
        do_op(32'h00012345, 32'h00000010, 5'd5, 32'h80000100, 0, 1'b0);
        do_op(32'h00012345, 32'h00000010, 5'd5, 32'h80000100, 4, 1'b0);
        // rd==0 drop
        do_op(32'd7, 32'd9, 5'd0, 32'h80000200, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_op(ra, rb, rd, pc, int'($urandom_range(0, 3)), 1'b0);
        end

        // timeout: multiplier never answers
        stub_en = 1'b0;
        offer(32'd3, 32'd4, 5'd9, 32'h80000300);
        tick();
        issue_valid_i = 1'b0;
        check("to_pulse", mul_valid_o, 1);
        for (int k = 2; k <= 17; k++) begin
            tick();
            check("to_err_early", error_o, 0);
            check("to_pend", pending_valid_o, 1);
        end
        tick();
        check("to_err", error_o, 1);
        check("to_ready", issue_ready_o, 1);
        check("to_pend_clr", pending_valid_o, 0);
        check("to_wbv", wb_valid_o, 0);
        spur_cyc = cyc + 1;
        repeat (4) begin
            tick();
            check("late_strobe_wbv", wb_valid_o, 0);
            check("err_hold", error_o, 1);
        end
        stub_en = 1'b1;
        do_op(32'd11, 32'd13, 5'd7, 32'h80000400, 1, 1'b1);

        // reset while waiting for the multiplier
        offer(32'd21, 32'd2, 5'd12, 32'h80000500);
        tick();
        issue_valid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mr_ready", issue_ready_o, 1);
        check("mr_mulv", mul_valid_o, 0);
        check("mr_opc", mul_opcode_o, 0);
        check("mr_pc", mul_pc_o, 0);
        check("mr_rd", mul_rd_idx_o, 0);
        check("mr_ra", mul_ra_operand_o, 0);
        check("mr_rb", mul_rb_operand_o, 0);
        check("mr_wbv", wb_valid_o, 0);
        check("mr_wbval", wb_value_o, 0);
        check("mr_wbrd", wb_rd_idx_o, 0);
        check("mr_wbpc", wb_pc_o, 0);
        check("mr_pend", pending_valid_o, 0);
        check("mr_pendrd", pending_rd_idx_o, 0);
        check("mr_err", error_o, 0);
        repeat (6) begin
            tick();
            check("mr_strobe_ignored", wb_valid_o, 0);
        end

`ifdef BIRISCV_MUL_DISPATCH_SKID_EN
        mv0 = mulv_count;
        offer(32'd2, 32'd3, 5'd3, 32'h80000600);
        tick();
        check("sk_pulse1", mul_valid_o, 1);
        check("sk_ready_busy", issue_ready_o, 1);
        offer(32'hFFFFFFFF, 32'd2, 5'd4, 32'h80000604);
        tick();
        issue_valid_i = 1'b0;
        check("sk_full", issue_ready_o, 0);
        check("sk_main_rd", mul_rd_idx_o, 3);
        wait_wb("sk_wb1_wait");
        check("sk_wb1_val", wb_value_o, 32'd6);
        check("sk_wb1_rd", wb_rd_idx_o, 3);
        wb_accept_i = 1'b1;
        tick();
        wb_accept_i = 1'b0;
        check("sk_gap_mulv", mul_valid_o, 0);
        tick();
        check("sk_pulse2", mul_valid_o, 1);
        check("sk_rd2", mul_rd_idx_o, 4);
        check("sk_ready2", issue_ready_o, 1);
        tick();
        wait_wb("sk_wb2_wait");
        check("sk_wb2_val", wb_value_o, 32'hFFFFFFFE);
        check("sk_wb2_rd", wb_rd_idx_o, 4);
        wb_accept_i = 1'b1;
        tick();
        wb_accept_i = 1'b0;
        repeat (3) tick();
        check("sk_pulses", 32'(mulv_count - mv0), 2);
`else
        mv0 = mulv_count;
        check("no_stray_pulse", 32'(mulv_count - mv0), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/biriscv_mul_dispatch.md
Name: biriscv_mul_dispatch

Overview:
- Sits between the issue stage and the iterative 16x16-based multiplier.
- Accepts one multiply op with a valid/ready handshake and emits a single-cycle start pulse plus operands to the multiplier.
- Tracks the one outstanding op (rd, pc), captures the multiplier result, and holds it for the writeback arbiter until accepted.
- Exposes the pending rd for hazard checks and detects a multiplier that never responds.

Parameters:
- TIMEOUT_CYCLES, 16, cycles in WAIT before abandoning the op and flagging error.
- TIMEOUT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- issue_valid_i  in  1  issue offers a multiply op
- issue_ready_o  out  1  block can accept the op this cycle
- issue_opcode_i  in  32  instruction word
- issue_pc_i  in  32  instruction pc
- issue_rd_idx_i  in  5  destination register
- issue_ra_operand_i  in  32  operand A
- issue_rb_operand_i  in  32  operand B
- mul_valid_o  out  1  one-cycle start pulse to the multiplier
- mul_opcode_o  out  32  latched opcode
- mul_pc_o  out  32  latched pc
- mul_rd_idx_o  out  5  latched rd
- mul_ra_operand_o  out  32  latched operand A
- mul_rb_operand_o  out  32  latched operand B
- mul_writeback_valid_i  in  1  multiplier result strobe
- mul_writeback_value_i  in  32  multiplier result, low 32 bits
- wb_valid_o  out  1  result pending for writeback
- wb_rd_idx_o  out  5  result destination
- wb_pc_o  out  32  result pc
- wb_value_o  out  32  result value
- wb_accept_i  in  1  arbiter consumes the result this cycle
- pending_valid_o  out  1  an op with rd!=0 is in flight or held
- pending_rd_idx_o  out  5  rd of that op
- error_o  out  1  sticky timeout flag

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; counter 0; error_o cleared.
- An op is accepted on any edge where issue_valid_i && issue_ready_o. All mul_* payload outputs are registered at accept.
- States:
  - IDLE: issue_ready_o=1. On accept with rd!=0, go to ISSUE. On accept with rd==0, drop the op (no dispatch, no writeback) and stay IDLE.
  - ISSUE: mul_valid_o=1 for exactly this cycle; clear the counter; go to WAIT.
  - WAIT: counter increments each cycle.
    - If mul_writeback_valid_i: capture the value into wb_value_o, set wb_valid_o, go to HOLD.
    - Else if counter==TIMEOUT_CYCLES-1: set error_o, discard the op, go to IDLE.
  - HOLD: wb_* outputs are stable while wb_accept_i=0. On wb_accept_i, clear wb_valid_o the next cycle and go to IDLE.
- Latency (multiplier responds 5 cycles after its start pulse):
  - accept in cycle N; mul_valid_o in N+1; mul_writeback_valid_i in N+6; wb_valid_o in N+7.
  - Earliest next accept is the cycle after wb_accept_i.
- pending_valid_o is 1 in ISSUE, WAIT and HOLD; pending_rd_idx_o equals mul_rd_idx_o.
- mul_writeback_valid_i outside WAIT is ignored (late or spurious strobe). This includes a strobe arriving after a timeout.
- rst_i asserted in any state returns to IDLE on the next edge. An in-flight result is lost; error_o is cleared.
- issue_ready_o is combinational from state only, never from issue_valid_i.

Optional Feature:
- Macro: BIRISCV_MUL_DISPATCH_SKID_EN.
- Defined:
  - A one-entry skid register (opcode, pc, rd, operands) is added.
  - issue_ready_o = skid empty, in any state.
  - An op accepted outside IDLE is parked in the skid entry.
  - On entry to IDLE with the skid full, the block moves directly to ISSUE using the skid entry and frees it. A rd==0 skid entry is dropped.
  - When HOLD and wb_accept_i coincide with a full skid, the skid op dispatches (mul_valid_o) on the second following cycle.
- Undefined: no skid; issue_ready_o = (state==IDLE).

Decomposition:
- Shared package holds:
  - state encodings: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, HOLD=2'd3.
  - default TIMEOUT_CYCLES.
  - multiplier response latency constant (5), used by the bench.
- Natural sub-module: biriscv_mul_dispatch_slot, the payload register (opcode, pc, rd, operands) with load/clear. It is instantiated once, or twice with the skid.

Test Plan:
- Basic: A=0x00012345, B=0x00000010, rd=5, pc=0x80000100, stub multiplier with latency 5 -> mul_valid_o in N+1 only; wb_valid_o in N+7 with value 0x00123450, rd=5, pc=0x80000100.
- Backpressure: same op with wb_accept_i held low 4 cycles -> wb_* stable; issue_ready_o=0 (no skid); pending_valid_o=1 with rd=5; IDLE the cycle after accept.
- rd=0: A=7, B=9, rd=0 -> no mul_valid_o, no wb_valid_o, issue_ready_o stays 1, pending_valid_o stays 0.
- Timeout: stub never responds -> error_o=1 at N+2+16; state IDLE. A strobe 0x55 arriving later produces no wb_valid_o.
- Reset mid-op: assert rst_i for 1 cycle in WAIT -> next cycle all outputs 0, ready=1; the later stub strobe is ignored.
- Skid (macro defined): two back-to-back ops with rd=3 (A=2, B=3) and rd=4 (A=0xFFFFFFFF, B=2) -> second accepted while busy; wb results 6 then 0xFFFFFFFE, in order; exactly two mul_valid_o pulses.
